// File: rtl/input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : input_buffer
// Description : Memory-mapped input peripheral in the 0x7800-0x783F window.
//               Synchronises 32 slide switches, synchronises and debounces
//               4 push-buttons, latches button press edges (W1C) and raises a
//               maskable, registered interrupt.
// Ports       : i_clk, i_rst_n (sync, active low)
//               i_addr/i_wdata/i_wren  LSU load/store access
//               i_io_sw/i_io_btn       raw asynchronous pad inputs
//               o_rdata/o_hit          combinational read data and decode
//               o_irq                  registered interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module input_buffer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int CNT_W           = 18
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wren,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_rdata,
  output logic        o_hit,
  output logic        o_irq
);

  localparam logic [0:0]       ST_STABLE   = 1'b0;
  localparam logic [0:0]       ST_COUNTING = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [9:0]       HIT_PAGE    = 10'h1E0;
  localparam logic [1:0]       REG_SW      = 2'd0;
  localparam logic [1:0]       REG_BTN     = 2'd1;
  localparam logic [1:0]       REG_EDGE    = 2'd2;
  localparam logic [1:0]       REG_IRQEN   = 2'd3;

  logic [31:0]      sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [3:0]       btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [3:0]       btn_state_q, btn_state_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       btn_db_q, btn_db_d;
  logic [3:0]       edge_q, edge_d;
  logic [3:0]       irqen_q, irqen_d;
  logic             irq_q, irq_d;

  logic [3:0]       btn_pressed;
  logic [3:0]       rise;
  logic [3:0]       edge_clr;
  logic             wr_hit;
  logic [1:0]       reg_sel;
  logic             unused_bits;

  assign o_hit       = (i_addr[15:6] == HIT_PAGE);
  assign reg_sel     = i_addr[5:4];
  assign wr_hit      = i_wren & o_hit;
  assign o_irq       = irq_q;
  assign unused_bits = ^{i_wdata[31:4], i_addr[3:0]};

  // Polarity is fixed before the synchroniser so that every button flop
  // holds "1 = pressed"; the all-zero reset state then means "released".
  assign btn_pressed = BTN_ACTIVE_LOW ? ~i_io_btn : i_io_btn;

  always_comb begin
    sw_meta_d   = i_io_sw;
    sw_sync_d   = sw_meta_q;
    btn_meta_d  = btn_pressed;
    btn_sync_d  = btn_meta_q;
    btn_state_d = btn_state_q;
    btn_db_d    = btn_db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    // Per-button debouncer: a new level is accepted only after it has been
    // seen on DEBOUNCE_CYCLES consecutive edges; any return to the accepted
    // level abandons the attempt.
    for (int i = 0; i < 4; i++) begin
      if (btn_state_q[i] == ST_STABLE) begin
        if (btn_sync_q[i] != btn_db_q[i]) begin
          btn_state_d[i] = ST_COUNTING;
          cnt_d[i]       = CNT_ONE;
        end
      end else begin
        if (btn_sync_q[i] == btn_db_q[i]) begin
          btn_state_d[i] = ST_STABLE;
          cnt_d[i]       = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          btn_db_d[i]    = btn_sync_q[i];
          btn_state_d[i] = ST_STABLE;
          cnt_d[i]       = '0;
        end else begin
          cnt_d[i]       = cnt_q[i] + CNT_ONE;
        end
      end
    end

    // Rise is taken from the next debounced value so the edge latches on the
    // same clock as the BTN bit. A set beats a simultaneous W1C clear.
    rise     = btn_db_d & ~btn_db_q;
    edge_clr = (wr_hit && (reg_sel == REG_EDGE)) ? i_wdata[3:0] : 4'h0;
    edge_d   = (edge_q & ~edge_clr) | rise;
    irqen_d  = (wr_hit && (reg_sel == REG_IRQEN)) ? i_wdata[3:0] : irqen_q;
    irq_d    = |(edge_d & irqen_d);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
      btn_state_q <= {4{ST_STABLE}};
      btn_db_q    <= '0;
      edge_q      <= '0;
      irqen_q     <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      btn_meta_q  <= btn_meta_d;
      btn_sync_q  <= btn_sync_d;
      btn_state_q <= btn_state_d;
      btn_db_q    <= btn_db_d;
      edge_q      <= edge_d;
      irqen_q     <= irqen_d;
      irq_q       <= irq_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    if (o_hit) begin
      case (reg_sel)
        REG_SW:    o_rdata = sw_sync_q;
        REG_BTN:   o_rdata = {28'b0, btn_db_q};
        REG_EDGE:  o_rdata = {28'b0, edge_q};
        REG_IRQEN: o_rdata = {28'b0, irqen_q};
        default:   o_rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
